univ_shift_reg: RTL and testbench
=================================

Name: univ_shift_reg

Overview:
Parametrised successor to the single-bit clear-able D flip-flop: a WIDTH-bit universal register with parallel load, logical/arithmetic shift, rotate, invert, enable and synchronous clear. It also has a saturating shift counter. It is the general storage/serialiser element for datapath blocks such as serial links, bit-serial ALUs and CRC front ends. One clock domain; no handshake; one operation per enabled cycle.

Parameters:
WIDTH, 8, register width in bits (>= 2)
RESET_VAL, 0, value loaded into Q by async reset and by SCLR (WIDTH bits)
CW, $clog2(WIDTH+1), width of shift counter (derived, not overridden)

Ports:
CLK  input  1  clock, rising-edge active
CLR  input  1  asynchronous, active-low reset
EN  input  1  operation enable; 0 = hold everything
SCLR  input  1  synchronous clear, active-high, overrides EN
MODE  input  3  operation select (see Behaviour)
D  input  WIDTH  parallel load data
SIN_L  input  1  serial in at MSB for right shift
SIN_R  input  1  serial in at LSB for left shift
Q  output  WIDTH  register contents
SOUT_L  output  1  Q[WIDTH-1], combinational from register
SOUT_R  output  1  Q[0], combinational from register
ZERO  output  1  1 when Q == 0, combinational from register
CNT  output  CW  shift/rotate operations since last load/clear, saturating at WIDTH

Behaviour:
- Reset: CLR=0 asynchronously forces Q=RESET_VAL and CNT=0 at once, independent of CLK. Held while CLR=0. Release is synchronous to CLK; the first update is on the first rising edge with CLR=1.
- Priority at each rising edge: CLR (async) > SCLR > EN=0 > MODE.
- SCLR=1: Q<=RESET_VAL, CNT<=0, regardless of EN and MODE.
- EN=0 (SCLR=0): Q and CNT hold.
- EN=1, SCLR=0, MODE:
  - 000 hold: Q, CNT unchanged
  - 001 load: Q<=D, CNT<=0
  - 010 shift left: Q<={Q[W-2:0],SIN_R}
  - 011 shift right: Q<={SIN_L,Q[W-1:1]}
  - 100 rotate left: Q<={Q[W-2:0],Q[W-1]}
  - 101 rotate right: Q<={Q[0],Q[W-1:1]}
  - 110 arithmetic shift right: Q<={Q[W-1],Q[W-1:1]}; SIN_L ignored
  - 111 invert: Q<=~Q; CNT unchanged
- CNT for modes 010-110: CNT<=CNT+1 if CNT<WIDTH, else stays at WIDTH (saturating, never wraps).
- Latency: Q, CNT update one edge after inputs are sampled. SOUT_L, SOUT_R and ZERO follow Q combinationally, with no extra cycle.
- Inputs are sampled only at the rising edge. Changes between edges have no effect. X on MODE while EN=0 must not corrupt state.
- Mid-operation reset: CLR asserted between edges clears immediately. Any pending operation is lost.

Test Plan (WIDTH=8, RESET_VAL=0):
- Async reset: Q loaded to 0xA5, then drop CLR mid-cycle (no edge) -> Q=0x00, CNT=0, ZERO=1 immediately. Raise CLR; the next edge with EN=0 -> Q stays 0x00.
- Load/enable: EN=1, MODE=001, D=0x3C -> Q=0x3C after 1 edge, CNT=0. Then EN=0, MODE=001, D=0xFF for 3 edges -> Q stays 0x3C.
- Serialise: load 0x81, then MODE=010, SIN_R=0, for 8 edges -> SOUT_L sequence 1,0,0,0,0,0,0,1 sampled before each edge. Final Q=0x00, ZERO=1, CNT=8. A 9th shift -> CNT stays 8.
- Rotate/arith: load 0x96; MODE=100 -> 0x2D; MODE=101 -> 0x96; MODE=110 -> 0xCB, then 0xE5; CNT=4.
- SCLR priority: Q=0x5A, EN=0, SCLR=1, MODE=010 -> Q=0x00, CNT=0 after 1 edge. Same with EN=1, MODE=111 -> Q=0x00, not 0xFF.
- Invert/shift-right serial-in: load 0x0F; MODE=111 -> 0xF0, CNT=0; MODE=011, SIN_L=1 -> 0xF8, CNT=1, SOUT_R=0.

Source files
------------

// File: rtl/univ_shift_reg_if.sv
// Signal bundle for the universal shift register: control/data in, register state out.
// The master modport drives controls and data; the slave modport is the register itself.
interface univ_shift_reg_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic             en;
    logic             sclr;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin_l;
    logic             sin_r;
    logic [WIDTH-1:0] q;
    logic             sout_l;
    logic             sout_r;
    logic             zero;
    logic [CW-1:0]    cnt;

    modport master (
        output en, sclr, mode, d, sin_l, sin_r,
        input  q, sout_l, sout_r, zero, cnt
    );

    modport slave (
        input  en, sclr, mode, d, sin_l, sin_r,
        output q, sout_l, sout_r, zero, cnt
    );
endinterface

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal register: load, logical/arithmetic shift, rotate, invert,
// synchronous clear, plus a saturating count of shift/rotate operations since the last load/clear.
module univ_shift_reg #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic             clk,
    input logic             clr,
    univ_shift_reg_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_INV  = 3'b111;

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_nxt;
    logic             shift_op;

    // Next-state selection; mode is only decoded when enabled so an unknown mode cannot leak into state
    always_comb begin
        q_nxt    = q_r;
        cnt_nxt  = cnt_r;
        shift_op = 1'b0;
        if (bus.sclr) begin
            q_nxt   = RESET_VAL;
            cnt_nxt = '0;
        end else if (bus.en) begin
            case (bus.mode)
                MODE_HOLD: q_nxt = q_r;
                MODE_LOAD: begin
                    q_nxt   = bus.d;
                    cnt_nxt = '0;
                end
                MODE_SHL: begin
                    q_nxt    = {q_r[WIDTH-2:0], bus.sin_r};
                    shift_op = 1'b1;
                end
                MODE_SHR: begin
                    q_nxt    = {bus.sin_l, q_r[WIDTH-1:1]};
                    shift_op = 1'b1;
                end
                MODE_ROL: begin
                    q_nxt    = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
                    shift_op = 1'b1;
                end
                MODE_ROR: begin
                    q_nxt    = {q_r[0], q_r[WIDTH-1:1]};
                    shift_op = 1'b1;
                end
                MODE_ASR: begin
                    q_nxt    = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
                    shift_op = 1'b1;
                end
                MODE_INV: q_nxt = ~q_r;
                default:  q_nxt = q_r;
            endcase
            // Counter saturates at WIDTH rather than wrapping
            if (shift_op && (cnt_r < CW'(WIDTH))) begin
                cnt_nxt = cnt_r + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q_r   <= RESET_VAL;
            cnt_r <= '0;
        end else begin
            q_r   <= q_nxt;
            cnt_r <= cnt_nxt;
        end
    end

    assign bus.q      = q_r;
    assign bus.cnt    = cnt_r;
    assign bus.sout_l = q_r[WIDTH-1];
    assign bus.sout_r = q_r[0];
    assign bus.zero   = (q_r == '0);
endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: directed vector table, multi-cycle corner sequences,
// and randomized traffic checked against an arithmetic reference model.
module tb_univ_shift_reg;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned CW    = $clog2(WIDTH + 1);

    typedef struct {
        logic       en;
        logic       sclr;
        logic [2:0] mode;
        logic [7:0] d;
        logic       sin_l;
        logic       sin_r;
        logic [7:0] exp_q;
        logic [3:0] exp_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic clr;
    int   checks = 0;
    int   errors = 0;
    int   mq = 0;
    int   mc = 0;
    vec_t vecs[18];

    univ_shift_reg_if #(.WIDTH(WIDTH)) if_i ();

    univ_shift_reg #(
        .WIDTH    (WIDTH),
        .RESET_VAL(8'h00)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(if_i)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic en, logic sclr, logic [2:0] mode, logic [7:0] d,
                                logic sin_l, logic sin_r, logic [7:0] eq, logic [3:0] ec);
        vec_t v;
        v.en = en; v.sclr = sclr; v.mode = mode; v.d = d;
        v.sin_l = sin_l; v.sin_r = sin_r; v.exp_q = eq; v.exp_cnt = ec;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(string tag, logic [7:0] eq, logic [3:0] ec);
        chk({tag, ".q"},      32'(if_i.q),      32'(eq));
        chk({tag, ".cnt"},    32'(if_i.cnt),    32'(ec));
        chk({tag, ".zero"},   32'(if_i.zero),   32'(eq == 8'h00));
        chk({tag, ".sout_l"}, 32'(if_i.sout_l), 32'(eq[7]));
        chk({tag, ".sout_r"}, 32'(if_i.sout_r), 32'(eq[0]));
    endtask

    task automatic drive(logic en, logic sclr, logic [2:0] mode, logic [7:0] d,
                         logic sin_l, logic sin_r);
        if_i.en = en; if_i.sclr = sclr; if_i.mode = mode;
        if_i.d = d; if_i.sin_l = sin_l; if_i.sin_r = sin_r;
    endtask

    // Reference behaviour expressed as integer arithmetic on an 8-bit value
    task automatic model_step();
        int m;
        if (if_i.sclr === 1'b1) begin
            mq = 0;
            mc = 0;
        end else if (if_i.en === 1'b1) begin
            m = int'(if_i.mode);
            case (m)
                1: begin mq = int'(if_i.d); mc = 0; end
                2: mq = ((mq * 2) + int'(if_i.sin_r)) % 256;
                3: mq = (mq / 2) + 128 * int'(if_i.sin_l);
                4: mq = ((mq * 2) % 256) + (mq / 128);
                5: mq = (mq / 2) + 128 * (mq % 2);
                6: mq = (mq / 2) + (mq >= 128 ? 128 : 0);
                7: mq = 255 - mq;
                default: ;
            endcase
            if (m >= 2 && m <= 6 && mc < 8) mc = mc + 1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] ser_exp;
        logic       r_en;

        vecs[0]  = mk(1, 0, 3'b001, 8'h3C, 0, 0, 8'h3C, 4'd0);
        vecs[1]  = mk(0, 0, 3'b001, 8'hFF, 0, 0, 8'h3C, 4'd0);
        vecs[2]  = mk(0, 0, 3'b001, 8'hFF, 0, 0, 8'h3C, 4'd0);
        vecs[3]  = mk(0, 0, 3'b001, 8'hFF, 0, 0, 8'h3C, 4'd0);
        vecs[4]  = mk(1, 0, 3'b001, 8'h96, 0, 0, 8'h96, 4'd0);
        vecs[5]  = mk(1, 0, 3'b100, 8'h00, 0, 0, 8'h2D, 4'd1);
        vecs[6]  = mk(1, 0, 3'b101, 8'h00, 0, 0, 8'h96, 4'd2);
        vecs[7]  = mk(1, 0, 3'b110, 8'h00, 0, 0, 8'hCB, 4'd3);
        vecs[8]  = mk(1, 0, 3'b110, 8'h00, 0, 0, 8'hE5, 4'd4);
        vecs[9]  = mk(1, 0, 3'b001, 8'h5A, 0, 0, 8'h5A, 4'd0);
        vecs[10] = mk(0, 1, 3'b010, 8'h00, 0, 1, 8'h00, 4'd0);
        vecs[11] = mk(1, 0, 3'b001, 8'h5A, 0, 0, 8'h5A, 4'd0);
        vecs[12] = mk(1, 1, 3'b111, 8'hFF, 0, 0, 8'h00, 4'd0);
        vecs[13] = mk(1, 0, 3'b001, 8'h0F, 0, 0, 8'h0F, 4'd0);
        vecs[14] = mk(1, 0, 3'b111, 8'h00, 0, 0, 8'hF0, 4'd0);
        vecs[15] = mk(1, 0, 3'b011, 8'h00, 1, 0, 8'hF8, 4'd1);
        vecs[16] = mk(1, 0, 3'b000, 8'hAA, 1, 1, 8'hF8, 4'd1);
        vecs[17] = mk(1, 0, 3'b010, 8'h00, 0, 1, 8'hF1, 4'd2);

        // Reset state while clr is held low from time zero
        clr = 1'b0;
        drive(0, 0, 3'b000, 8'h00, 0, 0);
        #3;
        check_outputs("reset", 8'h00, 4'd0);
        @(negedge clk);
        clr = 1'b1;

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].en, vecs[i].sclr, vecs[i].mode, vecs[i].d, vecs[i].sin_l, vecs[i].sin_r);
            tick();
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_cnt);
        end

        // Serialise 0x81 out of the MSB, then one extra shift to hit counter saturation
        ser_exp = 8'b1000_0001;
        drive(1, 0, 3'b001, 8'h81, 0, 0);
        tick();
        drive(1, 0, 3'b010, 8'h00, 0, 0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ser%0d.sout_l", i), 32'(if_i.sout_l), 32'(ser_exp[7-i]));
            tick();
        end
        check_outputs("ser_final", 8'h00, 4'd8);
        tick();
        check_outputs("ser_sat", 8'h00, 4'd8);

        // Async reset asserted between edges, held across an edge, then released
        drive(1, 0, 3'b001, 8'h4B, 0, 0);
        tick();
        drive(1, 0, 3'b101, 8'h00, 0, 0);
        tick();
        check_outputs("pre_rst", 8'hA5, 4'd1);
        drive(1, 0, 3'b001, 8'h3C, 0, 0);
        #3;
        clr = 1'b0;
        mq = 0;
        mc = 0;
        #1;
        check_outputs("async_rst", 8'h00, 4'd0);
        @(posedge clk);
        #1;
        check_outputs("rst_held", 8'h00, 4'd0);
        #2;
        clr = 1'b1;
        drive(0, 0, 3'b001, 8'hFF, 0, 0);
        tick();
        check_outputs("rst_release", 8'h00, 4'd0);

        // Unknown mode while disabled must leave state intact
        drive(1, 0, 3'b001, 8'hC3, 0, 0);
        tick();
        if_i.en = 1'b0;
        if_i.mode = 3'bxxx;
        tick();
        check_outputs("xmode_hold", 8'hC3, 4'd0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            r_en = ($urandom_range(0, 7) != 0);
            drive(r_en, ($urandom_range(0, 15) == 0), 3'($urandom_range(0, 7)),
                  8'($urandom), 1'($urandom), 1'($urandom));
            if (!r_en && $urandom_range(0, 3) == 0) if_i.mode = 3'bxxx;
            tick();
            check_outputs($sformatf("rnd%0d", n), 8'(mq), 4'(mc));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
